// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit drain:
//   - FSM state encodings (plain localparams so the encoding is legacy-friendly)
//   - DEFAULT_CLK_DIV : clocks per serial bit for 50 MHz / 115200 baud
//   - cnt_width()     : ceil(log2(n)), minimum 1, for sizing down-counters
// Optional feature macro used by importers: UART_TX_PARITY_EN (adds S_PARITY).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

  localparam int DEFAULT_CLK_DIV = 434;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// ---------------------------------------------------------------------------
// uart_tx_drain_if
// Read side of the byte queue as seen by the UART drain.
//   q_out      : queue head data, valid combinationally while q_pop is high
//   q_is_empty : queue empty flag
//   q_pop      : one-cycle pop strobe from the consumer
// Modports:
//   master : the consumer (uart_tx_drain) - drives q_pop
//   slave  : the queue - drives q_out / q_is_empty
// ---------------------------------------------------------------------------
interface uart_tx_drain_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] q_out;
  logic              q_is_empty;
  logic              q_pop;

  modport master (input q_out, input q_is_empty, output q_pop);
  modport slave  (output q_out, output q_is_empty, input q_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period timer. On reload the counter loads CLK_DIV-1 and then counts down
// to zero, where it holds. bit_end marks the last cycle of a bit period, so a
// reload on every bit_end yields periods of exactly CLK_DIV cycles.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset (counter cleared)
//   reload  in  : start a new bit period on the next edge
//   bit_end out : counter is zero
// ---------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic bit_end
);

  localparam int            CW         = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_drain
// Pops bytes from the byte queue whenever it is non-empty and serialises them
// LSB first onto txd as 8N1 frames (8E1 with UART_TX_PARITY_EN defined).
// Back-to-back frames are sent with no idle bit between stop and next start.
// Parameters:
//   CLK_DIV : clock cycles per serial bit (>= 2)
//   DATA_W  : byte width, must match the queue
// Ports:
//   m_clock in  : system clock, rising edge
//   p_reset in  : asynchronous active-low reset; aborts any frame in flight
//   q       if  : queue read interface (master modport: q_out, q_is_empty, q_pop)
//   txd     out : registered serial line, idle high
//   busy    out : registered, high while a frame is on the line
// Build option: define UART_TX_PARITY_EN to append an even-parity bit.
// ---------------------------------------------------------------------------
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DATA_W  = 8
) (
  input  logic                   m_clock,
  input  logic                   p_reset,
  uart_tx_drain_if.master        q,
  output logic                   txd,
  output logic                   busy
);

  localparam int            BW       = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                bit_end;
  logic                pop;
  logic                reload;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Pop when idle, or on the very last stop-bit cycle so the next start bit
  // follows the stop bit directly. Gated by reset so nothing leaves the
  // queue while the block is held in reset.
  assign pop = p_reset & ~q.q_is_empty &
               ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  // Every bit period (and the first one after a pop) starts with a reload.
  assign reload = pop | ((state_q != S_IDLE) & bit_end);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (m_clock),
    .rst_n   (p_reset),
    .reload  (reload),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = pop ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // q_out is only valid in the pop cycle, so everything derived from the
    // byte is captured here.
    if (pop) begin
      shift_d   = q.q_out;
      bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^q.q_out;
`endif
    end

    // txd/busy are decoded from the next state so the registered outputs line
    // up exactly with the state they describe.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign q.q_pop = pop;
  assign txd     = txd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_drain
// Bench for uart_tx_drain with CLK_DIV=4. The queue is modelled as an array
// with combinational head data; a line decoder reconstructs bytes from txd and
// a scoreboard matches them against the bytes pushed. Define
// UART_TX_PARITY_EN in the same way as for the RTL to check 8E1 framing.
// ---------------------------------------------------------------------------
module tb_uart_tx_drain;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_drain_if #(.DATA_W(8)) qif ();

  uart_tx_drain #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (8)
  ) dut (
    .m_clock (clk),
    .p_reset (rst_n),
    .q       (qif.master),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- queue model ----------------
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       pop_seen = 1'b0;
  logic [7:0] exp_q [$];

  always_comb begin
    qif.q_is_empty = (wr_ptr == rd_ptr);
    qif.q_out      = fifo_mem[rd_ptr[5:0]];
  end

  always @(negedge clk) pop_seen <= rst_n & qif.q_pop;
  always @(posedge clk) if (pop_seen) rd_ptr <= rd_ptr + 1;

  // ---------------- line decoder ----------------
  logic [7:0] rx_data_mem [0:63];
  logic       rx_par_mem  [0:63];
  logic       rx_ok_mem   [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  logic       dec_par = 1'b0;
  logic       dec_ok = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active <= 1'b0;
      dec_cnt    <= 0;
    end else if (!dec_active) begin
      if (txd == 1'b0) begin
        dec_active <= 1'b1;
        dec_cnt    <= 1;
        dec_ok     <= 1'b1;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if ((dec_cnt % CLK_DIV) == CLK_DIV / 2) begin
        if (dec_cnt / CLK_DIV == 0) begin
          dec_ok <= dec_ok & ~txd;
        end else if (dec_cnt / CLK_DIV <= 8) begin
          dec_byte[3'(dec_cnt / CLK_DIV - 1)] <= txd;
        end else if (dec_cnt / CLK_DIV == FRAME_BITS - 1) begin
          rx_data_mem[rx_wr[5:0]] <= dec_byte;
          rx_par_mem[rx_wr[5:0]]  <= dec_par;
          rx_ok_mem[rx_wr[5:0]]   <= dec_ok & txd;
          rx_wr                   <= rx_wr + 1;
          dec_active              <= 1'b0;
        end else begin
          dec_par <= txd;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Place pushes mid high phase so q_pop settles before the sampling edge.
  task automatic sync_push();
    @(posedge clk);
    #2;
  endtask

  task automatic push_now(input logic [7:0] b, input bit record);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
    if (record) exp_q.push_back(b);
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (qif.q_pop === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits for the pop, then checks every bit period of the frame and the
  // return to idle in the following cycle.
  task automatic expect_frame(input logic [7:0] data, input logic par, input string tag);
    bit   ok;
    bit   good;
    logic e;
    wait_pop(ok);
    check({tag, " pop_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    for (int b = 0; b < FRAME_BITS; b++) begin
      if (b == 0)                    e = 1'b0;
      else if (b <= 8)               e = data[b-1];
      else if (b == FRAME_BITS - 1)  e = 1'b1;
      else                           e = par;
      good = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
        @(negedge clk);
        if (txd !== e || busy !== 1'b1 || qif.q_pop !== 1'b0) good = 1'b0;
      end
      check($sformatf("%s bit%0d line=%0b", tag, b, e), 32'(good), 32'd1);
    end
    @(negedge clk);
    check({tag, " busy_clear"}, 32'(busy), 32'd0);
    check({tag, " txd_idle"}, 32'(txd), 32'd1);
  endtask

  // Compares every decoded frame against the scoreboard.
  task automatic drain_rx(input string tag);
    logic [7:0] e;
    while (rx_rd < rx_wr) begin
      if (exp_q.size() == 0) begin
        check({tag, " rx_unexpected"}, 32'(rx_data_mem[rx_rd[5:0]]), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check({tag, " rx_byte"}, 32'(rx_data_mem[rx_rd[5:0]]), 32'(e));
        check({tag, " rx_framing"}, 32'(rx_ok_mem[rx_rd[5:0]]), 32'd1);
`ifdef UART_TX_PARITY_EN
        check({tag, " rx_parity"}, 32'(rx_par_mem[rx_rd[5:0]]), 32'(^e));
`endif
      end
      rx_rd++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit good_txd, good_busy, good_pop;
    int npop;
    int stamp [2];
    bit saw_start;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h07, 1'b1};
    vecs[4] = '{8'h03, 1'b0};
    vecs[5] = '{8'h80, 1'b1};

    // --- reset held while the queue is non-empty ---
    sync_push();
    push_now(8'hAA, 1'b1);
    good_txd = 1; good_busy = 1; good_pop = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b1)       good_txd  = 0;
      if (busy !== 1'b0)      good_busy = 0;
      if (qif.q_pop !== 1'b0) good_pop  = 0;
    end
    check("reset txd_high", 32'(good_txd), 32'd1);
    check("reset busy_low", 32'(good_busy), 32'd1);
    check("reset no_pop", 32'(good_pop), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    expect_frame(8'hAA, 1'b0, "after_reset 0xAA");
    drain_rx("after_reset");

    // --- empty queue ---
    good_txd = 1; good_pop = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1)       good_txd = 0;
      if (qif.q_pop !== 1'b0) good_pop = 0;
    end
    check("empty txd_high", 32'(good_txd), 32'd1);
    check("empty no_pop", 32'(good_pop), 32'd1);

    // --- single-byte vectors ---
    for (int v = 0; v < 6; v++) begin
      sync_push();
      push_now(vecs[v].data, 1'b1);
      expect_frame(vecs[v].data, vecs[v].par, $sformatf("vec%0d 0x%02h", v, vecs[v].data));
      drain_rx($sformatf("vec%0d", v));
    end

    // --- back-to-back 0xA5, 0x3C ---
    sync_push();
    push_now(8'hA5, 1'b1);
    push_now(8'h3C, 1'b1);
    npop = 0;
    stamp[0] = 0;
    stamp[1] = 0;
    saw_start = 1'b0;
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      @(negedge clk);
      if (qif.q_pop === 1'b1) begin
        if (npop < 2) stamp[npop] = i;
        npop++;
        if (npop == 2) begin
          @(negedge clk);
          saw_start = (txd === 1'b0) && (busy === 1'b1);
        end
      end
    end
    check("b2b pop_count", 32'(npop), 32'd2);
    check("b2b pop_spacing", 32'(stamp[1] - stamp[0]), 32'(FRAME));
    check("b2b start_follows_stop", 32'(saw_start), 32'd1);
    check("b2b idle_after", 32'(busy), 32'd0);
    drain_rx("b2b");

    // --- reset in the middle of 0xFF ---
    sync_push();
    push_now(8'hFF, 1'b0);
    wait_pop(ok);
    check("abort pop_seen", 32'(ok), 32'd1);
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort txd_high", 32'(txd), 32'd1);
    check("abort busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    good_pop = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (qif.q_pop !== 1'b0 || txd !== 1'b1) good_pop = 0;
    end
    check("abort no_repop", 32'(good_pop), 32'd1);
    sync_push();
    push_now(8'h5A, 1'b1);
    expect_frame(8'h5A, 1'b0, "abort next 0x5A");
    repeat (4) @(negedge clk);
    drain_rx("abort");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    check("queue drained", 32'(rd_ptr), 32'(wr_ptr));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
